ecc_page_decoder: RTL and testbench
===================================

Name: ecc_page_decoder

Overview:
- Read-side ECC checker for the shared page buffer; counterpart of the write-path ECC encoder.
- Accepts one page request (page address), fetches that page's stored 8-bit ECC from the ECC storage read port, and collects the page's 8 x 16-bit words from SRAM.
- Computes the Hamming syndrome, corrects any single-bit error, and streams the corrected words to the egress port logic with valid/ready.

Parameters:
- DATA_WIDTH, 16, word width. Only 16 is supported.
- PAGE_WORDS, 8, words per page. Only 8 is supported; 128 data bits per page.
- ADDR_WIDTH, 11, page address width.
- ECC_WIDTH, 8, stored check bits per page.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- page_req_valid  in  1  page read request
- page_req_addr  in  11  page being read
- page_req_ready  out  1  high only in IDLE
- ecc_rd_en  out  1  ECC storage read strobe
- ecc_rd_addr  out  11  ECC storage address
- ecc_dout  in  8  stored ECC; valid 1 cycle after ecc_rd_en
- in_valid  in  1  SRAM word valid
- in_data  in  16  SRAM word
- in_ready  out  1  high only in COLLECT
- out_valid  out  1  corrected word valid
- out_data  out  16  corrected word
- out_last  out  1  marks word 7
- out_ready  in  1  downstream accept
- err_corrected  out  1  1-cycle pulse: single-bit error fixed
- err_uncorrectable  out  1  1-cycle pulse: invalid syndrome

Behaviour:
- Code: data bit i = w*16+b (word w, bit b) maps to the (i+1)-th non-power-of-two position in 1..136. Check bit k sits at position 2^k. Stored ecc[k] = XOR of data bits whose position has bit k set.
- Syndrome S = ecc_dout XOR (XOR of positions of all set data bits), 8 bits.
- Reset: state IDLE, all outputs 0, buffers and counters cleared.
- IDLE:
  - page_req_ready=1.
  - On page_req_valid: ecc_rd_en=1 and ecc_rd_addr=page_req_addr in the same cycle (combinational). Latch the address and go to COLLECT.
- COLLECT:
  - in_ready=1. The stored ECC is captured on the first COLLECT cycle.
  - Each in_valid stores the word at word_cnt (3 bits), XORs its position contribution into the running syndrome, and increments word_cnt.
  - Gaps in in_valid are allowed.
  - Accepting word 7 goes to CHECK.
- CHECK (1 cycle): evaluate S.
  - S==0: no action.
  - S is a power of two: check-bit error; data unchanged; err_corrected pulses.
  - S is a data position <=136: flip that data bit in the buffer; err_corrected pulses.
  - Otherwise (S>136): data unchanged; err_uncorrectable pulses.
  - Pulses are asserted in the cycle after CHECK. Go to DRAIN.
- DRAIN:
  - out_valid=1 and out_data=buffer[rd_cnt]. A transfer occurs when out_valid&&out_ready; then rd_cnt increments.
  - out_last=1 when rd_cnt==7. The transfer of the last word goes to IDLE.
  - out_data is held stable while stalled.
- Latency:
  - Word 7 accepted in cycle T: CHECK at T+1, first out_valid at T+2.
  - With out_ready held high, word 7 leaves at T+9.
  - Next page_req accepted no earlier than T+10.
- Only one page is in flight; there is no overlap between DRAIN and COLLECT.
- Mid-operation reset returns to IDLE in the next cycle. The partial page is discarded and no error pulse fires.
- in_valid outside COLLECT and page_req_valid outside IDLE are ignored (not consumed).
- Counters wrap naturally at 8; word_cnt is cleared on entering COLLECT.

Optional Feature:
- Macro: ECC_ERR_COUNT_EN.
- When defined:
  - Add output ports corr_count[15:0] and uncorr_count[15:0].
  - Both are saturating counters, incremented with the respective pulse and held at 16'hFFFF.
  - Both reset to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package hydra_ecc_pkg holds:
  - constants PAGE_WORDS, DATA_WIDTH, ECC_WIDTH and MAX_POS=136;
  - the state enum typedef {IDLE, COLLECT, CHECK, DRAIN};
  - function data_pos(i), returning the code position of data bit i.
- Sub-module ecc_word_syndrome (combinational): inputs word index and 16-bit word; output 8-bit XOR of positions of its set bits. It is shared with the encoder.

Test Plan:
- Clean page: words 16'h0000..16'h0007 with correct ECC -> output identical, out_last on word 7, no error pulses, first out_valid 2 cycles after word 7.
- Single data flip: word 3 bit 5 inverted (data bit 53, position 60) -> S=60, output word 3 restored, err_corrected pulse once.
- Check-bit flip: stored ECC bit 4 inverted -> S=16, data unchanged, err_corrected pulse.
- Double data flip: data bits 0 and 1 (positions 3 and 5) -> S=6, a data position; bench checks that data bit 2 is miscorrected (no double-error detection). Separately, force S=200 -> err_uncorrectable pulse, data unchanged.
- Backpressure and gaps: in_valid 50% random, out_ready low for 3 cycles at word 4 -> out_data stable during stall, all 8 words in order, page_req_ready low until the last word transfers.
- Reset during COLLECT after 5 words -> IDLE next cycle, no output, and a fresh page then decodes correctly. With ECC_ERR_COUNT_EN, 3 corrected pages -> corr_count=3.

Source files
------------

// File: rtl/ecc_page_decoder_pkg.sv
// Shared constants, state type and code-position helpers for the page ECC datapath.
// Data bit i occupies the (i+1)-th non-power-of-two position; check bit k sits at 2^k.
package hydra_ecc_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned PAGE_WORDS = 8;
   localparam int unsigned ADDR_WIDTH = 11;
   localparam int unsigned ECC_WIDTH  = 8;
   localparam int unsigned MAX_POS    = 136;

   typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DRAIN} state_e;

   // Skip over each power-of-two slot at or below the running position.
   function automatic logic [7:0] data_pos(input logic [6:0] i);
      logic [7:0] p;
      p = {1'b0, i} + 8'd1;
      for (int k = 0; k < 8; k++) begin
         if (p >= 8'(1 << k)) p = p + 8'd1;
      end
      return p;
   endfunction

   // Inverse of data_pos for a non-power-of-two position: pos - 2 - floor(log2(pos)).
   function automatic logic [6:0] data_index(input logic [7:0] pos);
      logic [7:0] msb;
      msb = 8'd0;
      for (int k = 0; k < 8; k++) begin
         if (pos[k]) msb = 8'(k);
      end
      return 7'(pos - 8'd2 - msb);
   endfunction

endpackage

// File: rtl/ecc_page_decoder_if.sv
// Handshake bundle between the page ECC decoder and its request, SRAM, ECC-store and egress peers.
interface ecc_page_decoder_if;
   import hydra_ecc_pkg::*;

   logic                  page_req_valid;
   logic [ADDR_WIDTH-1:0] page_req_addr;
   logic                  page_req_ready;
   logic                  ecc_rd_en;
   logic [ADDR_WIDTH-1:0] ecc_rd_addr;
   logic [ECC_WIDTH-1:0]  ecc_dout;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  out_ready;
   logic                  err_corrected;
   logic                  err_uncorrectable;

   modport slave (
      input  page_req_valid, page_req_addr, ecc_dout, in_valid, in_data, out_ready,
      output page_req_ready, ecc_rd_en, ecc_rd_addr, in_ready, out_valid, out_data, out_last,
             err_corrected, err_uncorrectable
   );

   modport master (
      output page_req_valid, page_req_addr, ecc_dout, in_valid, in_data, out_ready,
      input  page_req_ready, ecc_rd_en, ecc_rd_addr, in_ready, out_valid, out_data, out_last,
             err_corrected, err_uncorrectable
   );

endinterface

// File: rtl/ecc_page_decoder_syndrome.sv
// XOR of the code positions of every set bit in one page word; shared with the encoder.
module ecc_word_syndrome
   import hydra_ecc_pkg::*;
(
   input  logic [2:0]            word_idx,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [ECC_WIDTH-1:0]  syndrome
);

   always_comb begin
      syndrome = '0;
      for (int b = 0; b < 16; b++) begin
         if (data[b]) syndrome = syndrome ^ data_pos({word_idx, 4'(b)});
      end
   end

endmodule

// File: rtl/ecc_page_decoder.sv
// Read-side page ECC checker: collects 8 words, corrects single-bit errors, streams them out.
// Define ECC_ERR_COUNT_EN to add saturating corrected/uncorrectable event counters.
module ecc_page_decoder
   import hydra_ecc_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   ecc_page_decoder_if.slave   bus
`ifdef ECC_ERR_COUNT_EN
   ,
   output logic [15:0]         corr_count,
   output logic [15:0]         uncorr_count
`endif
);

   state_e                                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]                   addr_q, addr_d;
   logic [PAGE_WORDS-1:0][DATA_WIDTH-1:0]   page_q, page_d;
   logic [2:0]                              word_cnt_q, word_cnt_d;
   logic [2:0]                              rd_cnt_q, rd_cnt_d;
   logic [ECC_WIDTH-1:0]                    syn_q, syn_d;
   logic                                    first_q, first_d;
   logic                                    err_corr_q, err_corr_d;
   logic                                    err_uncorr_q, err_uncorr_d;

   logic                  req_ready, rd_en, in_rdy;
   logic [ECC_WIDTH-1:0]  word_syn;
   logic                  syn_pow2, syn_data;
   logic [6:0]            flip_idx;

   ecc_word_syndrome u_word_syn (
      .word_idx (word_cnt_q),
      .data     (bus.in_data),
      .syndrome (word_syn)
   );

   assign syn_pow2 = (syn_q != '0) && ((syn_q & (syn_q - 8'd1)) == '0);
   assign syn_data = (syn_q != '0) && !syn_pow2 && (syn_q <= 8'(MAX_POS));
   assign flip_idx = data_index(syn_q);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      page_d       = page_q;
      word_cnt_d   = word_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      syn_d        = syn_q;
      first_d      = first_q;
      err_corr_d   = 1'b0;
      err_uncorr_d = 1'b0;
      req_ready    = 1'b0;
      rd_en        = 1'b0;
      in_rdy       = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.page_req_valid) begin
               rd_en      = 1'b1;
               addr_d     = bus.page_req_addr;
               word_cnt_d = '0;
               syn_d      = '0;
               first_d    = 1'b1;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            in_rdy  = 1'b1;
            first_d = 1'b0;
            // Stored ECC arrives one cycle after the read strobe, i.e. on the first COLLECT cycle.
            syn_d = syn_q ^ (first_q ? bus.ecc_dout : '0) ^ (bus.in_valid ? word_syn : '0);
            if (bus.in_valid) begin
               page_d[word_cnt_q] = bus.in_data;
               word_cnt_d         = word_cnt_q + 3'd1;
               if (word_cnt_q == 3'd7) state_d = COLLECT == COLLECT ? CHECK : CHECK;
            end
         end
         CHECK: begin
            if (syn_pow2) begin
               err_corr_d = 1'b1;
            end else if (syn_data) begin
               page_d[flip_idx[6:4]][flip_idx[3:0]] = ~page_q[flip_idx[6:4]][flip_idx[3:0]];
               err_corr_d = 1'b1;
            end else if (syn_q != '0) begin
               err_uncorr_d = 1'b1;
            end
            rd_cnt_d = '0;
            state_d  = DRAIN;
         end
         DRAIN: begin
            if (bus.out_ready) begin
               rd_cnt_d = rd_cnt_q + 3'd1;
               if (rd_cnt_q == 3'd7) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         page_q       <= '0;
         word_cnt_q   <= '0;
         rd_cnt_q     <= '0;
         syn_q        <= '0;
         first_q      <= 1'b0;
         err_corr_q   <= 1'b0;
         err_uncorr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         page_q       <= page_d;
         word_cnt_q   <= word_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         syn_q        <= syn_d;
         first_q      <= first_d;
         err_corr_q   <= err_corr_d;
         err_uncorr_q <= err_uncorr_d;
      end
   end

   assign bus.page_req_ready    = req_ready;
   assign bus.ecc_rd_en         = rd_en;
   assign bus.ecc_rd_addr       = rd_en ? bus.page_req_addr : addr_q;
   assign bus.in_ready          = in_rdy;
   assign bus.out_valid         = (state_q == DRAIN);
   assign bus.out_data          = (state_q == DRAIN) ? page_q[rd_cnt_q] : '0;
   assign bus.out_last          = (state_q == DRAIN) && (rd_cnt_q == 3'd7);
   assign bus.err_corrected     = err_corr_q;
   assign bus.err_uncorrectable = err_uncorr_q;

`ifdef ECC_ERR_COUNT_EN
   logic [15:0] corr_cnt_q, uncorr_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         if (err_corr_d && (corr_cnt_q != 16'hFFFF))     corr_cnt_q   <= corr_cnt_q + 16'd1;
         if (err_uncorr_d && (uncorr_cnt_q != 16'hFFFF)) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
      end
   end

   assign corr_count   = corr_cnt_q;
   assign uncorr_count = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_ecc_page_decoder.sv
// Scoreboard bench for ecc_page_decoder: a driver queues expected words/flags, a monitor checks.
module tb_ecc_page_decoder;

   typedef struct packed {logic [15:0] data; logic last;} exp_word_t;
   typedef struct packed {logic corr; logic uncorr;} exp_err_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ecc_page_decoder_if bus ();

`ifdef ECC_ERR_COUNT_EN
   logic [15:0] corr_count, uncorr_count;
`endif

   ecc_page_decoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ECC_ERR_COUNT_EN
      ,
      .corr_count   (corr_count),
      .uncorr_count (uncorr_count)
`endif
   );

   exp_word_t wq[$];
   exp_err_t  eq[$];
   int        checks = 0;
   int        errors = 0;
   int        cyc = 0;
   int        t7 = 0;
   int        out_idx = 0;
   bit        stall_en = 0;
   int        stall_cnt = 0;
   logic [7:0] bad_ecc = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Reference code built by walking positions 1..136 and skipping powers of two.
   function automatic logic [7:0] model_ecc(input logic [7:0][15:0] d);
      logic [127:0] flat;
      logic [7:0]   e;
      int           idx;
      flat = d;
      e    = 8'h00;
      idx  = 0;
      for (int p = 1; p <= 136; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (flat[idx]) e = e ^ 8'(p);
            idx++;
         end
      end
      return e;
   endfunction

   task automatic push_page(input logic [7:0][15:0] d, input logic corr, input logic uncorr);
      exp_err_t ee;
      exp_word_t ew;
      for (int w = 0; w < 8; w++) begin
         ew.data = d[w];
         ew.last = (w == 7);
         wq.push_back(ew);
      end
      ee.corr   = corr;
      ee.uncorr = uncorr;
      eq.push_back(ee);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.ecc_dout = bad_ecc;
   endtask

   task automatic send_page(input logic [10:0] addr, input logic [7:0][15:0] d,
                            input logic [7:0] ecc, input int nwords, input bit gaps);
      int n;
      bit rdy;
      bad_ecc            = ecc ^ 8'h96;
      bus.page_req_valid = 1'b1;
      bus.page_req_addr  = addr;
      n   = 0;
      rdy = 1'b0;
      while (!rdy && n < 300) begin
         @(negedge clk);
         rdy = bus.page_req_ready;
         if (rdy) begin
            check("ecc_rd_en", 32'(bus.ecc_rd_en), 32'd1);
            check("ecc_rd_addr", 32'(bus.ecc_rd_addr), 32'(addr));
         end
         tick();
         n++;
      end
      if (!rdy) timeout("page_req_accept");
      bus.ecc_dout       = ecc;
      bus.page_req_valid = 1'b0;
      for (int w = 0; w < nwords; w++) begin
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = d[w];
         n   = 0;
         rdy = 1'b0;
         while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = bus.in_ready;
            if (rdy && w == 7) t7 = cyc;
            tick();
            n++;
         end
         if (!rdy) timeout("in_word_accept");
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((wq.size() != 0 || eq.size() != 0) && n < 300) begin
         tick();
         n++;
      end
      if (wq.size() != 0 || eq.size() != 0) timeout("drain");
   endtask

   // Output sink: holds out_ready low for three cycles while word 4 is presented.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_en && out_idx == 4 && stall_cnt < 3) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
         end else begin
            bus.out_ready = 1'b1;
         end
      end
   end

   // Monitor: pops expected words and error flags whenever the DUT presents output.
   initial begin
      logic       prev_valid;
      logic       held_valid;
      logic [15:0] held_data;
      exp_err_t   me;
      exp_word_t  mw;
      prev_valid = 1'b0;
      held_valid = 1'b0;
      held_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.out_valid && !prev_valid) begin
               out_idx = 0;
               if (eq.size() == 0) begin
                  timeout("unexpected_page_output");
               end else begin
                  me = eq.pop_front();
                  check("err_corrected", 32'(bus.err_corrected), 32'(me.corr));
                  check("err_uncorrectable", 32'(bus.err_uncorrectable), 32'(me.uncorr));
                  check("first_valid_latency", 32'(cyc - t7), 32'd2);
               end
            end else if (bus.err_corrected || bus.err_uncorrectable) begin
               check("stray_err_pulse", {30'd0, bus.err_corrected, bus.err_uncorrectable}, 32'd0);
            end
            if (bus.out_valid) check("page_req_ready_in_drain", 32'(bus.page_req_ready), 32'd0);
            if (bus.out_valid && !bus.out_ready) begin
               if (held_valid) check("stall_data_stable", 32'(bus.out_data), 32'(held_data));
               held_data  = bus.out_data;
               held_valid = 1'b1;
            end else begin
               held_valid = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
               if (wq.size() == 0) begin
                  timeout("unexpected_word");
               end else begin
                  mw = wq.pop_front();
                  check($sformatf("out_data[%0d]", out_idx), 32'(bus.out_data), 32'(mw.data));
                  check($sformatf("out_last[%0d]", out_idx), 32'(bus.out_last), 32'(mw.last));
               end
               out_idx++;
            end
         end
         prev_valid = bus.out_valid;
      end
   end

   initial begin
      logic [7:0][15:0] d1, d2, d3, d4, tx, ex;
      logic [7:0]       e1, e2, e3, e4;

      bus.page_req_valid = 1'b0;
      bus.page_req_addr  = '0;
      bus.ecc_dout       = '0;
      bus.in_valid       = 1'b0;
      bus.in_data        = '0;
      for (int w = 0; w < 8; w++) begin
         d1[w] = 16'(w);
         d2[w] = 16'h1234 + 16'(w) * 16'h0101;
         d3[w] = 16'hBEEF ^ (16'(w) << 4);
         d4[w] = 16'h8001 + 16'(w) * 16'h2222;
      end
      e1 = model_ecc(d1);
      e2 = model_ecc(d2);
      e3 = model_ecc(d3);
      e4 = model_ecc(d4);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_page_req_ready", 32'(bus.page_req_ready), 32'd1);
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_last", 32'(bus.out_last), 32'd0);
      check("reset_out_data", 32'(bus.out_data), 32'd0);
      check("reset_ecc_rd_en", 32'(bus.ecc_rd_en), 32'd0);
      check("reset_err", {30'd0, bus.err_corrected, bus.err_uncorrectable}, 32'd0);
`ifdef ECC_ERR_COUNT_EN
      check("reset_corr_count", 32'(corr_count), 32'd0);
      check("reset_uncorr_count", 32'(uncorr_count), 32'd0);
`endif

      // in_valid while idle must not be taken
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hFFFF;
      @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.in_valid = 1'b0;

      // clean page
      push_page(d1, 1'b0, 1'b0);
      send_page(11'h123, d1, e1, 8, 1'b0);

      // word 3 bit 5 flipped: position 60
      tx = d2;
      tx[3][5] = ~tx[3][5];
      push_page(d2, 1'b1, 1'b0);
      send_page(11'h045, tx, e2, 8, 1'b0);

      // stored check bit 4 flipped: S=16
      push_page(d2, 1'b1, 1'b0);
      send_page(11'h7FF, d2, e2 ^ 8'h10, 8, 1'b0);

      // data bits 0 and 1 flipped: S=6 miscorrects data bit 2
      tx = d2;
      tx[0] = tx[0] ^ 16'h0003;
      ex = d2;
      ex[0] = ex[0] ^ 16'h0007;
      push_page(ex, 1'b1, 1'b0);
      send_page(11'h100, tx, e2, 8, 1'b0);

      // S=200 is beyond the code length
      push_page(d2, 1'b0, 1'b1);
      send_page(11'h001, d2, e2 ^ 8'd200, 8, 1'b0);

      // random input gaps plus a 3-cycle output stall on word 4
      wait_drain();
      stall_cnt = 0;
      stall_en  = 1'b1;
      push_page(d3, 1'b0, 1'b0);
      send_page(11'h2AA, d3, e3, 8, 1'b1);
      wait_drain();
      stall_en = 1'b0;
      check("stall_cycles_applied", 32'(stall_cnt), 32'd3);
`ifdef ECC_ERR_COUNT_EN
      check("corr_count", 32'(corr_count), 32'd3);
      check("uncorr_count", 32'(uncorr_count), 32'd1);
`endif

      // reset after 5 words: partial page is dropped
      send_page(11'h0F0, d3, e3, 5, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset_page_req_ready", 32'(bus.page_req_ready), 32'd1);
      check("midreset_in_ready", 32'(bus.in_ready), 32'd0);
      check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (12) tick();

      push_page(d4, 1'b0, 1'b0);
      send_page(11'h0F0, d4, e4, 8, 1'b0);
      wait_drain();
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
